redundant_cpa_pipe: RTL and testbench



---
 rtl/redundant_cpa_pipe.sv | 90 +++++++++
 tb/tb_redundant_cpa_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/redundant_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : redundant_cpa_pipe
// Brief    : Pipelined carry-propagate adder that resolves a redundant
//            (sum, carry) pair into binary, one carry segment per stage.
// Revision : 1.0 - initial release
// ============================================================================
module redundant_cpa_pipe #(
    parameter int WIDTH  = 28,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_s,
    input  logic [WIDTH-1:0] in_t,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
);

    localparam int SEGW = WIDTH / STAGES;

    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [WIDTH-1:0]  r_s   [STAGES];
    logic [WIDTH-1:0]  r_t   [STAGES];
    logic [WIDTH-1:0]  r_res [STAGES];
    logic [SEGW:0]     w_seg [STAGES];
    logic [STAGES-1:0] w_en;
    logic [STAGES-1:0] w_unused_ops;

    // Flattened ready chain: a stage may load if it or any later stage is
    // empty, or the consumer is taking the last item.
    for (genvar k = 0; k < STAGES; k++) begin : g_en
        assign w_en[k] = ~(&r_v[STAGES-1:k]) | out_ready;
    end

    // Operand copies are kept full width; only the upper segments are consumed.
    for (genvar k = 0; k < STAGES; k++) begin : g_unused
        assign w_unused_ops[k] = ^{r_s[k], r_t[k]};
    end

    always_comb begin
        w_seg[0] = {1'b0, in_s[SEGW-1:0]} + {1'b0, in_t[SEGW-1:0]};
        for (int k = 1; k < STAGES; k++) begin
            w_seg[k] = {1'b0, r_s[k-1][k*SEGW +: SEGW]}
                     + {1'b0, r_t[k-1][k*SEGW +: SEGW]}
                     + {{SEGW{1'b0}}, r_c[k-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v <= '0;
            r_c <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_s[k]   <= '0;
                r_t[k]   <= '0;
                r_res[k] <= '0;
            end
        end else begin
            if (w_en[0]) begin
                r_v[0]              <= in_valid;
                r_s[0]              <= in_s;
                r_t[0]              <= in_t;
                r_res[0]            <= '0;
                r_res[0][SEGW-1:0]  <= w_seg[0][SEGW-1:0];
                r_c[0]              <= w_seg[0][SEGW];
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_en[k]) begin
                    r_v[k]                   <= r_v[k-1];
                    r_s[k]                   <= r_s[k-1];
                    r_t[k]                   <= r_t[k-1];
                    r_res[k]                 <= r_res[k-1];
                    r_res[k][k*SEGW +: SEGW] <= w_seg[k][SEGW-1:0];
                    r_c[k]                   <= w_seg[k][SEGW];
                end
            end
        end
    end

    assign in_ready  = w_en[0];
    assign out_valid = r_v[STAGES-1];
    assign out_sum   = {r_c[STAGES-1], r_res[STAGES-1]};

endmodule
`default_nettype wire

// File: tb/tb_redundant_cpa_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_redundant_cpa_pipe
// Brief    : Self-checking bench: directed cases plus randomized traffic
//            scored against an arithmetic reference queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_redundant_cpa_pipe;

    localparam int WIDTH  = 28;
    localparam int STAGES = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_t;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out_sum;

    int     n_checks = 0;
    int     n_errs   = 0;
    longint sb[$];
    logic   held     = 1'b0;
    longint held_sum = 0;

    redundant_cpa_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_t      (in_t),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: handshakes are sampled mid-cycle, ahead of the edge that
    // completes them.
    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                check_value("hold_valid", longint'(out_valid), 1);
                check_value("hold_sum", longint'(out_sum), held_sum);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_value("sb_extra_output", longint'(sb.size()), 1);
                end else begin
                    check_value("sb_sum", longint'(out_sum), sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(longint'(in_s) + longint'(in_t));
            end
            held     = out_valid && !out_ready;
            held_sum = longint'(out_sum);
        end
    end

    task automatic send_one(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] t,
                            input longint exp);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_s      = s;
        in_t      = t;
        #1;
        check_value("one_in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("one_ov_early", longint'(out_valid), 0);
        @(posedge clk); #1;
        check_value("one_ov", longint'(out_valid), 1);
        check_value("one_sum", longint'(out_sum), exp);
        @(posedge clk); #1;
        check_value("one_ov_after", longint'(out_valid), 0);
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk); #1;
        check_value(tag, longint'(sb.size()), 0);
        check_value({tag, "_ov"}, longint'(out_valid), 0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_s = '0; in_t = '0; out_ready = 1'b1;

        // Reset takes effect without a clock edge
        #2 rst = 1'b1;
        #1;
        check_value("rst_ov", longint'(out_valid), 0);
        check_value("rst_sum", longint'(out_sum), 0);
        check_value("rst_ir", longint'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_hold_ov", longint'(out_valid), 0);
        check_value("rst_hold_sum", longint'(out_sum), 0);
        check_value("rst_hold_ir", longint'(in_ready), 1);
        rst = 1'b0;

        send_one(28'hFFFFFFF, 28'h0000001, 64'h10000000);
        send_one(28'hFFFFFFF, 28'hFFFFFFF, 64'h1FFFFFFE);
        send_one(28'h0000000, 28'h0000000, 64'h0);

        // Back-to-back stream: outputs in cycles 2..17 exactly
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int j = 0; j < 19; j++) begin
            check_value("stream_ov", longint'(out_valid), longint'(j >= 2 && j <= 17));
            if (j < 16) begin
                in_valid = 1'b1;
                in_s     = WIDTH'($urandom);
                in_t     = WIDTH'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
        end
        drain("stream_drain");

        // Backpressure: consumer stalls for 5 cycles while input keeps coming
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            in_s      = WIDTH'($urandom);
            in_t      = WIDTH'($urandom);
            out_ready = !(c >= 6 && c < 11);
            #1;
            if (c >= 6 && c < 11) begin
                check_value("bp_in_ready", longint'(in_ready), 0);
                check_value("bp_out_valid", longint'(out_valid), 1);
            end
        end
        drain("bp_drain");

        // Random traffic on both sides
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            in_s      = WIDTH'($urandom);
            in_t      = WIDTH'($urandom);
            out_ready = ($urandom_range(2) != 0);
        end
        drain("rand_drain");

        // Reset with two items in flight
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b1; in_s = 28'h1234567; in_t = 28'h0ABCDEF;
        @(posedge clk); #1;
        in_s = 28'h7654321; in_t = 28'h0FEDCBA;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_value("pre_rst_ov", longint'(out_valid), 1);
        rst = 1'b1;
        sb.delete();
        #1;
        check_value("mid_rst_ov", longint'(out_valid), 0);
        check_value("mid_rst_sum", longint'(out_sum), 0);
        check_value("mid_rst_ir", longint'(in_ready), 1);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        send_one(28'd5, 28'd7, 64'd12);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
